instr_loader: RTL and testbench

Boot-time program loader that writes the instruction memory, the write-side counterpart of the core's instruction fetch. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them to consecutive instruction-memory word addresses. It verifies a trailing XOR checksum and holds the core in reset until a load completes cleanly. It sits between the board-level byte source and the instruction memory write port, beside `PC_main`/`InstructionMemory`.

---
 rtl/instr_loader_pkg.sv | 9 +
 rtl/word_assembler.sv | 54 +++++
 rtl/instr_loader.sv | 153 +++++++++++++++
 tb/tb_instr_loader.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package instr_loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_CHK, S_DONE, S_ERROR
  } state_e;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/word_assembler.sv
// Collects stream bytes into little-endian words and keeps the running XOR
// of every data byte; word_done_o fires on the transfer that completes a word.
module word_assembler
  import instr_loader_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clr_i,
  input  logic                      en_i,
  input  logic [7:0]                byte_i,
  output logic [8*WORD_BYTES-1:0]   word_o,
  output logic                      word_done_o,
  output logic [7:0]                csum_o
);
  localparam int LW = $clog2(WORD_BYTES);
  localparam logic [LW-1:0] LAST = LW'(WORD_BYTES - 1);

  logic [LW-1:0]               lane_q, lane_d;
  logic [8*(WORD_BYTES-1)-1:0] sh_q, sh_d;
  logic [7:0]                  csum_q, csum_d;

  // The completing byte bypasses the shift register so the word is whole
  // in the same cycle as the final transfer.
  assign word_done_o = en_i && (lane_q == LAST);
  assign word_o      = {byte_i, sh_q};
  assign csum_o      = csum_q;

  always_comb begin
    lane_d = lane_q;
    sh_d   = sh_q;
    csum_d = csum_q;
    if (clr_i) begin
      lane_d = '0;
      sh_d   = '0;
      csum_d = '0;
    end else if (en_i) begin
      lane_d = (lane_q == LAST) ? '0 : lane_q + 1'b1;
      sh_d   = {byte_i, sh_q[8*(WORD_BYTES-1)-1:8]};
      csum_d = csum_q ^ byte_i;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lane_q <= '0;
      sh_q   <= '0;
      csum_q <= '0;
    end else begin
      lane_q <= lane_d;
      sh_q   <= sh_d;
      csum_q <= csum_d;
    end
  end
endmodule

// File: rtl/instr_loader.sv
// Boot loader: parses a count header, streams words into instruction memory,
// verifies the trailing XOR checksum and releases the core only on success.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam int CW = 8 * HDR_BYTES;
  localparam logic [CW:0] CAP = (CW+1)'(1) << ADDR_WIDTH;

  state_e                  state_q, state_d;
  logic [CW-1:0]           count_q, count_d;
  logic [ADDR_WIDTH:0]     idx_q, idx_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    hold_q, hold_d;
  logic [CW-1:0]           hdr_count;
  logic                    xfer, asm_clr, asm_en, word_done;
  logic [31:0]             word;
  logic [7:0]              csum;

  assign byte_ready = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                      (state_q == S_DATA) || (state_q == S_CHK);
  assign busy       = byte_ready;
  assign xfer       = byte_valid && byte_ready;
  assign asm_en     = xfer && (state_q == S_DATA);

  word_assembler u_asm (
    .clock       (clock),
    .reset       (reset),
    .clr_i       (asm_clr),
    .en_i        (asm_en),
    .byte_i      (byte_data),
    .word_o      (word),
    .word_done_o (word_done),
    .csum_o      (csum)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    done_d    = done_q;
    err_d     = err_q;
    hold_d    = hold_q;
    asm_clr   = 1'b0;
    hdr_count = {byte_data, count_q[7:0]};
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_HDR0;
          idx_d   = '0;
          asm_clr = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          hold_d  = 1'b1;
        end
      end
      S_HDR0: begin
        if (xfer) begin
          count_d[7:0] = byte_data;
          state_d      = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          count_d = hdr_count;
          if ({1'b0, hdr_count} > CAP) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else if (hdr_count == '0) begin
            state_d = S_CHK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (word_done) begin
          we_d    = 1'b1;
          addr_d  = idx_q[ADDR_WIDTH-1:0];
          wdata_d = word;
          idx_d   = idx_q + 1'b1;
          if (CW'(idx_d) == count_q) state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (xfer) begin
          if (byte_data == csum) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign core_hold = hold_q;
  assign done      = done_q;
  assign error     = err_q;
endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench: streams are generated here, and expected writes/outcome
// come from parsing the stream with the format rules directly.
module tb_instr_loader;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset, start, byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready, mem_we, core_hold, busy, done, error;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  stream[$];
  logic [39:0] got_wr[$];

  instr_loader #(.ADDR_WIDTH(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .core_hold  (core_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (mem_we) got_wr.push_back({mem_addr, mem_wdata});

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_stream(input int nw, input bit bad);
    logic [31:0] w;
    logic [7:0]  cs;
    stream.delete();
    stream.push_back(nw[7:0]);
    stream.push_back(nw[15:8]);
    cs = 8'h00;
    for (int k = 0; k < nw; k++) begin
      w = $urandom;
      for (int b = 0; b < 4; b++) begin
        stream.push_back(w[8*b +: 8]);
        cs ^= w[8*b +: 8];
      end
    end
    stream.push_back(bad ? (cs ^ 8'h01) : cs);
  endtask

  // Expected results derived from the stream format alone.
  task automatic check_load(input string tag);
    int          cnt, nexp;
    logic [7:0]  cs;
    logic [31:0] w;
    bit          ok;
    cnt = {stream[1], stream[0]};
    if (cnt > (1 << AW)) begin
      nexp = 0;
      ok   = 1'b0;
    end else begin
      nexp = cnt;
      cs   = 8'h00;
      for (int j = 2; j < 2 + 4*cnt; j++) cs ^= stream[j];
      ok = (stream[2 + 4*cnt] == cs);
    end
    check({tag, ".nwr"}, got_wr.size(), nexp);
    for (int k = 0; k < nexp && k < got_wr.size(); k++) begin
      w = {stream[2+4*k+3], stream[2+4*k+2], stream[2+4*k+1], stream[2+4*k]};
      check($sformatf("%s.wr%0d", tag, k), got_wr[k], {k[AW-1:0], w});
    end
    check({tag, ".done"}, done, ok);
    check({tag, ".error"}, error, !ok);
    check({tag, ".hold"}, core_hold, !ok);
    got_wr.delete();
  endtask

  // Pulse start, then feed bytes with random valid gaps until the loader
  // stops accepting or stop_after bytes have transferred.
  task automatic send(input int gap, input bit mid_start, input int stop_after);
    int i   = 0;
    int cyc = 0;
    int lim = (stop_after >= 0) ? stop_after : stream.size();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    while (i < lim && !(done || error) && cyc < 5000) begin
      byte_valid = ($urandom_range(99) >= gap);
      byte_data  = stream[i];
      start      = mid_start && (i == 6);
      if (byte_valid && byte_ready) i++;
      @(negedge clock);
      cyc++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    if (stop_after < 0) begin
      cyc = 0;
      while (!(done || error) && cyc < 20) begin
        @(negedge clock);
        cyc++;
      end
      check("finish", done || error, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (3) @(negedge clock);
    check("rst.hold",  core_hold,  1'b1);
    check("rst.we",    mem_we,     1'b0);
    check("rst.busy",  busy,       1'b0);
    check("rst.done",  done,       1'b0);
    check("rst.err",   error,      1'b0);
    check("rst.ready", byte_ready, 1'b0);
    check("rst.addr",  mem_addr,   '0);
    check("rst.wdata", mem_wdata,  '0);
    reset = 1'b0;
    @(negedge clock);

    // Directed two-word load, good then corrupted checksum.
    stream = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    stream.push_back(8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE);
    send(0, 1'b0, -1);
    check_load("dir2");
    stream[10] = stream[10] ^ 8'h01;
    send(0, 1'b0, -1);
    check_load("dir2bad");

    // Empty loads.
    stream = {8'h00, 8'h00, 8'h00};
    send(0, 1'b0, -1);
    check_load("zero");
    stream = {8'h00, 8'h00, 8'h01};
    send(0, 1'b0, -1);
    check_load("zerobad");

    // Oversized header, then recovery with one word.
    build_stream(257, 1'b0);
    send(0, 1'b0, -1);
    check_load("over");
    build_stream(1, 1'b0);
    send(0, 1'b0, -1);
    check_load("after_over");

    // Random sizes, gaps, and an ignored mid-load start.
    for (int t = 0; t < 6; t++) begin
      build_stream($urandom_range(2, 20), ($urandom_range(3) == 0));
      send(40, 1'b1, -1);
      check_load($sformatf("rnd%0d", t));
    end

    build_stream(256, 1'b0);
    send(20, 1'b0, -1);
    check("full.last", (got_wr.size() == 256) ? got_wr[255][39:32] : 8'h00, 8'hFF);
    check_load("full");

    // Reset after five data bytes: one word already written, core held.
    build_stream(3, 1'b0);
    send(30, 1'b0, 7);
    #1 reset = 1'b1;
    #1;
    check("midrst.hold",  core_hold,  1'b1);
    check("midrst.we",    mem_we,     1'b0);
    check("midrst.busy",  busy,       1'b0);
    check("midrst.ready", byte_ready, 1'b0);
    check("midrst.nwr",   got_wr.size(), 5 / 4);
    got_wr.delete();
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    build_stream(4, 1'b0);
    send(10, 1'b0, -1);
    check_load("postrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
